timer_counter: RTL and testbench

Parametrised timer/counter, successor to the single-mode up-counter. Adds up/down direction, runtime terminal value, wrap/one-shot/auto-reload modes, compare-match, sticky interrupt with clear, and an optional clock prescaler. Sits beside the bus register block: software programs `limit`/`compare`/`mode`, and `irq` goes to the interrupt controller.

---
 rtl/timer_counter.sv | 171 +++++++++++++++++
 tb/tb_timer_counter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Up/down timer-counter with wrap, one-shot and auto-reload modes, compare-match and a sticky irq.
// Latency: count/tc/cmp_match/irq update on the rising edge after the tick or load is sampled.
// Backpressure: none; load pre-empts a tick and enable low freezes the count.
//
// Optional feature: define TIMER_PRESCALE_EN to build the tick prescaler.
// Without it the prescale port is ignored and every RUN cycle is a tick.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   enable          run request (level)
//   load/load_value load pulse and value (also the auto-reload value)
//   dir             0 = up, 1 = down
//   mode            00 wrap, 01 one-shot, 10 auto-reload, 11 behaves as wrap
//   limit           up terminal value / down wrap reload value
//   compare         compare-match value
//   prescale        tick divider minus one (prescaler builds only)
//   irq_clr         clears the sticky irq (a same-cycle set wins)
//   count, tc, cmp_match, irq, running   status outputs
module timer_counter #(
  parameter int WIDTH       = 16,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_value,
  input  logic                   dir,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       limit,
  input  logic [WIDTH-1:0]       compare,
  input  logic [PRESC_WIDTH-1:0] prescale,
  input  logic                   irq_clr,
  output logic [WIDTH-1:0]       count,
  output logic                   tc,
  output logic                   cmp_match,
  output logic                   irq,
  output logic                   running
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_ONESHOT = 2'b01;
  localparam logic [1:0] MODE_RELOAD  = 2'b10;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             cmp_q, cmp_d;
  logic             irq_q, irq_d;

  logic run_cyc;
  logic tick;
  logic terminal;
  logic match;
  logic oneshot_term;

  // A RUN cycle only counts if enable is still high and no load pre-empts it.
  assign run_cyc = (state_q == S_RUN) && enable && !load;

`ifdef TIMER_PRESCALE_EN
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic                   presc_hit;

  assign presc_hit = (presc_q == prescale);
  assign tick      = run_cyc && presc_hit;

  always_comb begin
    presc_d = presc_q;
    if (load) begin
      presc_d = '0;
    end else if (run_cyc) begin
      presc_d = presc_hit ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  // Port kept for a uniform interface; folded into a sink so it is visibly unused.
  logic unused_prescale;
  assign unused_prescale = ^prescale;
  assign tick            = run_cyc;
`endif

  assign terminal     = dir ? (count_q == '0) : (count_q == limit);
  assign match        = (count_q == compare);
  assign oneshot_term = tick && terminal && (mode == MODE_ONESHOT);

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      cmp_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      cmp_q   <= cmp_d;
      irq_q   <= irq_d;
    end
  end

  // Next-state logic. A load freezes the state, except that it releases DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!load && enable) state_d = S_RUN;
      end
      S_RUN: begin
        if (!load) begin
          if (!enable)          state_d = S_IDLE;
          else if (oneshot_term) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (load || !enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (tick) begin
      if (!terminal) begin
        count_d = dir ? count_q - 1'b1 : count_q + 1'b1;
      end else begin
        case (mode)
          MODE_ONESHOT: count_d = count_q;
          MODE_RELOAD:  count_d = load_value;
          default:      count_d = dir ? limit : '0;
        endcase
      end
    end

    tc_d  = tick && terminal;
    cmp_d = tick && match;

    // Set has priority over clear.
    if (tc_d || cmp_d)  irq_d = 1'b1;
    else if (irq_clr)   irq_d = 1'b0;
    else                irq_d = irq_q;
  end

  // Outputs.
  always_comb begin
    count     = count_q;
    tc        = tc_q;
    cmp_match = cmp_q;
    irq       = irq_q;
    running   = (state_q == S_RUN);
  end

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: stimulus pushes hand-computed expectations,
// a monitor pops one per cycle just after the clock edge and compares.
module tb_timer_counter;

  localparam int W  = 8;
  localparam int PW = 8;
`ifdef TIMER_PRESCALE_EN
  localparam int PDIV = 4;
`else
  localparam int PDIV = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          load;
  logic [W-1:0]  load_value;
  logic          dir;
  logic [1:0]    mode;
  logic [W-1:0]  limit;
  logic [W-1:0]  compare;
  logic [PW-1:0] prescale;
  logic          irq_clr;
  logic [W-1:0]  count;
  logic          tc;
  logic          cmp_match;
  logic          irq;
  logic          running;

  timer_counter #(.WIDTH(W), .PRESC_WIDTH(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .dir        (dir),
    .mode       (mode),
    .limit      (limit),
    .compare    (compare),
    .prescale   (prescale),
    .irq_clr    (irq_clr),
    .count      (count),
    .tc         (tc),
    .cmp_match  (cmp_match),
    .irq        (irq),
    .running    (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [W-1:0] cnt;
    logic       tc;
    logic       cm;
    logic       irq;
    logic       run;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   nstep  = 0;

  // Expectation for the outputs right after the next rising edge.
  task automatic step(input logic [W-1:0] c, input logic t, input logic m,
                      input logic i, input logic r);
    exp_t e;
    e.id  = nstep;
    e.cnt = c;
    e.tc  = t;
    e.cm  = m;
    e.irq = i;
    e.run = r;
    nstep++;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: outputs are presented every cycle, so one pop per edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({count, tc, cmp_match, irq, running} !== {e.cnt, e.tc, e.cm, e.irq, e.run}) begin
        errors++;
        $display("FAIL step%0d got cnt=%0d tc=%b cmp=%b irq=%b run=%b exp cnt=%0d tc=%b cmp=%b irq=%b run=%b",
                 e.id, count, tc, cmp_match, irq, running, e.cnt, e.tc, e.cm, e.irq, e.run);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; load = 1'b0; load_value = '0; dir = 1'b0;
    mode = 2'b00; limit = 8'd5; compare = 8'd200; prescale = '0; irq_clr = 1'b0;
    @(negedge clk);

    // Reset state
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0);

    // Up, wrap, limit 5
    enable = 1'b1;
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(2, 0, 0, 0, 1);
    step(3, 0, 0, 0, 1);
    step(4, 0, 0, 0, 1);
    step(5, 0, 0, 0, 1);
    step(0, 1, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    step(2, 0, 0, 1, 1);
    irq_clr = 1'b1;
    step(3, 0, 0, 0, 1);
    irq_clr = 1'b0;
    step(4, 0, 0, 0, 1);
    step(5, 0, 0, 0, 1);
    step(0, 1, 0, 1, 1);
    enable = 1'b0;
    step(0, 0, 0, 1, 0);
    irq_clr = 1'b1;
    step(0, 0, 0, 0, 0);
    irq_clr = 1'b0;

    // Down, one-shot from 3
    dir = 1'b1; mode = 2'b01; load = 1'b1; load_value = 8'd3;
    step(3, 0, 0, 0, 0);
    load = 1'b0; enable = 1'b1;
    step(3, 0, 0, 0, 1);
    step(2, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    load = 1'b1; load_value = 8'd7;
    step(7, 0, 0, 1, 0);
    load = 1'b0; enable = 1'b0; irq_clr = 1'b1;
    step(7, 0, 0, 0, 0);
    irq_clr = 1'b0;

    // Up, auto-reload 250..252
    dir = 1'b0; mode = 2'b10; limit = 8'd252; load = 1'b1; load_value = 8'd250;
    step(250, 0, 0, 0, 0);
    load = 1'b0; enable = 1'b1;
    step(250, 0, 0, 0, 1);
    step(251, 0, 0, 0, 1);
    step(252, 0, 0, 0, 1);
    step(250, 1, 0, 1, 1);
    step(251, 0, 0, 1, 1);
    step(252, 0, 0, 1, 1);
    step(250, 1, 0, 1, 1);
    enable = 1'b0; irq_clr = 1'b1;
    step(250, 0, 0, 0, 0);
    irq_clr = 1'b0;

    // Compare match at 2, set-vs-clear priority
    mode = 2'b00; limit = 8'd5; compare = 8'd2; load = 1'b1; load_value = 8'd0;
    step(0, 0, 0, 0, 0);
    load = 1'b0; enable = 1'b1;
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(2, 0, 0, 0, 1);
    step(3, 0, 1, 1, 1);
    step(4, 0, 0, 1, 1);
    step(5, 0, 0, 1, 1);
    irq_clr = 1'b1;
    step(0, 1, 0, 1, 1);
    irq_clr = 1'b0;
    step(1, 0, 0, 1, 1);
    irq_clr = 1'b1;
    step(2, 0, 0, 0, 1);
    irq_clr = 1'b0;
    step(3, 0, 1, 1, 1);
    step(4, 0, 0, 1, 1);
    step(5, 0, 0, 1, 1);

    // Load at count == limit pre-empts the terminal tick
    load = 1'b1; load_value = 8'd9;
    step(9, 0, 0, 1, 1);
    load = 1'b0;
    step(10, 0, 0, 1, 1);

    // Reset mid-run wins over load/enable
    rst = 1'b1; load = 1'b1;
    step(0, 0, 0, 0, 0);
    rst = 1'b0; load = 1'b0; enable = 1'b0;
    step(0, 0, 0, 0, 0);

    // Prescale 3: every 4th cycle with the prescaler, every cycle without
    prescale = 8'd3; compare = 8'd200; limit = 8'd200; enable = 1'b1;
    step(0, 0, 0, 0, 1);
    for (int k = 1; k <= 8; k++) begin
      step(W'(k / PDIV), 0, 0, 0, 1);
    end
    enable = 1'b0;

    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
